// File: rtl/shared_nand_arbiter.sv
// shared_nand_arbiter
//   Round-robin front end that time-shares one W-bit bitwise NAND datapath
//   (W nand_gate instances) among NUM_REQ requesters. Each transaction is
//   IDLE (arbitrate/accept) -> EVAL (NAND the latched operands) ->
//   RESP (hold result until the granted requester takes it).
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   req_valid   [NUM_REQ]    per-requester request valid
//   req_ready   [NUM_REQ]    request accept, one-hot or zero (combinational)
//   req_inA     [NUM_REQ*W]  operand A, requester i at [i*W +: W]
//   req_inB     [NUM_REQ*W]  operand B, same packing
//   resp_valid  [NUM_REQ]    result valid, one-hot or zero
//   resp_ready  [NUM_REQ]    result accept (only the granted bit matters)
//   resp_outY   [W]          registered ~(A & B)
//   busy                     high whenever not IDLE

module nand_gate (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module shared_nand_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*W-1:0] req_inA,
  input  logic [NUM_REQ*W-1:0] req_inB,
  output logic [NUM_REQ-1:0]   resp_valid,
  input  logic [NUM_REQ-1:0]   resp_ready,
  output logic [W-1:0]         resp_outY,
  output logic                 busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] ptr_nxt;
  logic          win_found;
  logic [W-1:0]  a_q, b_q, nand_y;
  logic [NUM_REQ-1:0] gnt_oh;

  // Shared datapath: one nand_gate per bit, fed by the latched operands.
  for (genvar i = 0; i < W; i++) begin : g_nand
    nand_gate u_nand (.a(a_q[i]), .b(b_q[i]), .y(nand_y[i]));
  end

  // Round-robin search starting at rr_ptr. The candidate index is built one
  // bit wider than rr_ptr so the wrap is an explicit subtract of NUM_REQ,
  // which keeps non-power-of-two NUM_REQ correct.
  always_comb begin
    logic [PW:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
      if (!win_found && req_valid[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  // rst_n gates req_ready so no accept is ever advertised while in reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && win_found) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    gnt_oh = '0;
    gnt_oh[gnt_idx] = 1'b1;
  end

  assign ptr_nxt = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      resp_outY  <= '0;
      resp_valid <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_found) begin
          a_q     <= req_inA[win_idx*W +: W];
          b_q     <= req_inB[win_idx*W +: W];
          gnt_idx <= win_idx;
          busy    <= 1'b1;
          state   <= EVAL;
        end
        EVAL: begin
          resp_outY  <= nand_y;
          resp_valid <= gnt_oh;
          state      <= RESP;
        end
        RESP: if (resp_ready[gnt_idx]) begin
          resp_valid <= '0;
          busy       <= 1'b0;
          rr_ptr     <= ptr_nxt;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_nand_arbiter.sv
module tb_shared_nand_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_inA, req_inB;
  logic [7:0]  resp_outY;
  logic        busy;

  // Second instance: W=1, NUM_REQ=2 for the truth table.
  logic       rst1_n;
  logic [1:0] v1, rdy1, rv1, rr1, a1, b1;
  logic       y1, busy1;

  int errs = 0;
  int checks = 0;

  typedef struct { logic [3:0] oh; logic [7:0] y; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  shared_nand_arbiter #(.NUM_REQ(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_inA(req_inA), .req_inB(req_inB), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_outY(resp_outY), .busy(busy));

  shared_nand_arbiter #(.NUM_REQ(2), .W(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .req_valid(v1), .req_ready(rdy1),
    .req_inA(a1), .req_inB(b1), .resp_valid(rv1),
    .resp_ready(rr1), .resp_outY(y1), .busy(busy1));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] oh, input logic [7:0] y);
    exp_t e;
    e.oh = oh;
    e.y  = y;
    sb.push_back(e);
  endtask

  task automatic drive_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 20);
    chk("wait_idle", {31'd0, busy}, 32'd0);
    drive_step();
  endtask

  // Monitor: every consumed response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && |(resp_valid & resp_ready)) begin
      if (sb.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL sb_unexpected resp_valid=%0h y=%0h", resp_valid, resp_outY);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_resp_valid", {28'd0, resp_valid}, {28'd0, e.oh});
        chk("sb_resp_outY", {24'd0, resp_outY}, {24'd0, e.y});
      end
    end
  end

  initial begin
    logic [3:0] tt;
    rst_n = 1'b0;
    rst1_n = 1'b0;
    v1 = '0; rr1 = 2'b11; a1 = '0; b1 = '0;
    req_valid  = 4'($urandom);
    resp_ready = 4'($urandom);
    req_inA    = $urandom;
    req_inB    = $urandom;
    #3;
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("rst_outY", {24'd0, resp_outY}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    drive_step();
    drive_step();

    // ---- Test 1: single request from requester 0 ----
    rst_n      = 1'b1;
    req_inA    = {8'h12, 8'hFF, 8'hAA, 8'hF0};
    req_inB    = {8'h34, 8'h0F, 8'h55, 8'h3C};
    req_valid  = 4'b0001;
    resp_ready = 4'b1111;
    push(4'b0001, 8'hCF);
    @(negedge clk);
    chk("t1_req_ready", {28'd0, req_ready}, 32'h1);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    drive_step();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("t1_eval_busy", {31'd0, busy}, 32'd1);
    chk("t1_eval_noresp", {28'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("t1_resp_valid", {28'd0, resp_valid}, 32'h1);
    chk("t1_outY", {24'd0, resp_outY}, 32'hCF);
    @(negedge clk);
    chk("t1_back_idle", {31'd0, busy}, 32'd0);
    drive_step();

    // ---- Test 2: all four requesting, order 0,1,2,3,0, accepts 3 apart ----
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req_valid = 4'b1111;
    push(4'b0001, 8'hCF);
    push(4'b0010, 8'hFF);
    push(4'b0100, 8'hF0);
    push(4'b1000, 8'hEF);
    push(4'b0001, 8'hCF);
    for (int c = 0; c <= 12; c++) begin
      logic [3:0] e;
      @(negedge clk);
      e = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      chk("t2_grant_seq", {28'd0, req_ready}, {28'd0, e});
    end
    drive_step();
    req_valid = 4'b0000;
    wait_idle();

    // ---- Test 3: round-robin wrap after requester 3 ----
    req_valid = 4'b1000;
    push(4'b1000, 8'hEF);
    @(negedge clk);
    chk("t3_grant3", {28'd0, req_ready}, 32'h8);
    drive_step();
    req_valid = 4'b1001;
    push(4'b0001, 8'hCF);
    @(negedge clk);
    chk("t3_eval_noready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("t3_resp_noready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("t3_wrap_to0", {28'd0, req_ready}, 32'h1);
    drive_step();
    req_valid = 4'b0000;
    wait_idle();

    // ---- Test 4: response backpressure (pointer now at 1) ----
    req_valid = 4'b0100;
    push(4'b0100, 8'hF0);
    @(negedge clk);
    chk("t4_grant2", {28'd0, req_ready}, 32'h4);
    drive_step();
    req_valid  = 4'b1011;
    resp_ready = 4'b1011;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_bp_resp_valid", {28'd0, resp_valid}, 32'h4);
      chk("t4_bp_outY", {24'd0, resp_outY}, 32'hF0);
      chk("t4_bp_req_ready", {28'd0, req_ready}, 32'd0);
      chk("t4_bp_busy", {31'd0, busy}, 32'd1);
    end
    drive_step();
    resp_ready = 4'b1111;
    req_valid  = 4'b0000;
    @(negedge clk);
    chk("t4_release_valid", {28'd0, resp_valid}, 32'h4);
    @(negedge clk);
    chk("t4_idle_busy", {31'd0, busy}, 32'd0);
    chk("t4_idle_resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("t4_outY_held", {24'd0, resp_outY}, 32'hF0);
    drive_step();

    // ---- Test 5: reset during EVAL and during RESP (pointer now at 3) ----
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t5_grant1", {28'd0, req_ready}, 32'h2);
    drive_step();
    req_valid = 4'b0000;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_eval_abort_busy", {31'd0, busy}, 32'd0);
    chk("t5_eval_abort_valid", {28'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("t5_eval_abort_valid2", {28'd0, resp_valid}, 32'd0);
    drive_step();
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t5_ptr_reset", {28'd0, req_ready}, 32'h2);
    drive_step();
    req_valid = 4'b0000;
    drive_step();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_resp_abort_valid", {28'd0, resp_valid}, 32'd0);
      chk("t5_resp_abort_busy", {31'd0, busy}, 32'd0);
    end
    drive_step();
    req_valid = 4'b1100;
    push(4'b0100, 8'hF0);
    @(negedge clk);
    chk("t5_lowest_active", {28'd0, req_ready}, 32'h4);
    drive_step();
    req_valid = 4'b0000;
    wait_idle();

    // ---- Test 6: truth table on W=1, NUM_REQ=2 ----
    tt = 4'b0111;
    rst1_n = 1'b1;
    for (int p = 0; p < 4; p++) begin
      logic [1:0] pv;
      int n;
      drive_step();
      pv = 2'(p);
      v1 = 2'b01 << pv[0];
      a1 = pv[1] ? v1 : 2'b00;
      b1 = pv[0] ? v1 : 2'b00;
      n = 0;
      do begin @(negedge clk); n++; end while (rdy1 == 2'b00 && n < 10);
      chk("tt_req_ready", {30'd0, rdy1}, {30'd0, v1});
      drive_step();
      v1 = 2'b00;
      n = 0;
      do begin @(negedge clk); n++; end while (rv1 == 2'b00 && n < 10);
      chk("tt_resp_valid", {30'd0, rv1}, {30'd0, 2'b01 << pv[0]});
      chk("tt_outY", {31'd0, y1}, {31'd0, tt[p]});
    end

    // Drain: every expected response must have been consumed.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
